clk_div_prog: RTL

Runtime-programmable integer clock divider and the parametrised successor to the fixed-N divider. It produces a 50%-duty divided clock for both even and odd divisors. Odd divisors use a negative-edge helper flop. The divisor can be reloaded while running and takes effect only at a period boundary, so no runt pulses occur. Enable starts and stops cleanly, and a one-cycle `tick` strobe marks each period start for synchronous consumers in the `clk` domain.

---
 rtl/clk_div_prog.sv | 82 ++++++++
 1 files changed

// File: rtl/clk_div_prog.sv
// clk_div_prog: runtime-programmable 50%-duty integer clock divider with
// boundary-aligned divisor reload, clean enable start/stop and a period tick.
module clk_div_prog #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             div_load,
  input  logic [WIDTH-1:0] div_val,
  output logic             clkout,
  output logic             tick,
  output logic             running,
  output logic [WIDTH-1:0] div_active
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t           state, state_nx;
  logic [WIDTH-1:0] cnt, cnt_nx, pend_val, pend_val_nx, div_nx, div_clamp, half;
  logic             clk_p, clk_p_nx, clk_n, tick_nx, pend, pend_nx, bound;
  always_comb begin
    div_clamp   = (div_val < WIDTH'(2)) ? WIDTH'(2) : div_val;
    half        = div_active >> 1;
    bound       = (state == RUN) && (cnt == div_active - WIDTH'(1));
    state_nx    = state;
    cnt_nx      = cnt;
    clk_p_nx    = clk_p;
    tick_nx     = 1'b0;
    div_nx      = div_active;
    pend_nx     = pend;
    pend_val_nx = pend_val;
    if (state == IDLE) begin
      cnt_nx   = '0;
      clk_p_nx = en;
      tick_nx  = en;
      state_nx = en ? RUN : IDLE;
      if (div_load) div_nx = div_clamp;
    end else begin
      cnt_nx = cnt + WIDTH'(1);
      if (cnt_nx == half) clk_p_nx = 1'b0;
      if (div_load) begin
        pend_nx     = 1'b1;
        pend_val_nx = div_clamp;
      end
      // A load on the boundary edge itself stays pending for the next boundary
      if (bound) begin
        cnt_nx   = '0;
        clk_p_nx = en;
        tick_nx  = en;
        state_nx = en ? RUN : IDLE;
        if (pend) div_nx = pend_val;
        if (!div_load) pend_nx = 1'b0;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      clk_p      <= 1'b0;
      tick       <= 1'b0;
      div_active <= WIDTH'(DEFAULT_DIV);
      pend       <= 1'b0;
      pend_val   <= '0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      clk_p      <= clk_p_nx;
      tick       <= tick_nx;
      div_active <= div_nx;
      pend       <= pend_nx;
      pend_val   <= pend_val_nx;
    end
  end
  // Half-cycle stretch for odd divisors
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) clk_n <= 1'b0;
    else        clk_n <= clk_p;
  end
  assign clkout  = clk_p | (div_active[0] & clk_n);
  assign running = (state == RUN);
endmodule
